insn_queue: RTL and testbench

INSN_QUEUE -- requirements
Module: insn_queue

---
 rtl/insn_queue.sv | 90 +++++++++
 tb/tb_insn_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/insn_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer; flush and async reset empty it.
module insn_queue #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [LEN_INSN-1:0]      insn_i,
  input  logic [MEM_INSN_ADDR-1:0] addr_i,
  output logic                     stall_o,
  output logic                     valid_o,
  output logic [LEN_INSN-1:0]      insn_o,
  output logic [MEM_INSN_ADDR-1:0] addr_o,
  input  logic                     stall_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [LEN_INSN-1:0]      insn;
    logic [MEM_INSN_ADDR-1:0] addr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  entry_t        head;

  assign stall_o = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  assign push = valid_i && !stall_o && !flush_i;
  assign pop  = valid_o && !stall_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty queue masks it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{insn: insn_i, addr: addr_i};
    end
  end

  always_comb begin
    head = '0;
    if (valid_o) head = mem_q[rd_ptr_q];
  end

  assign insn_o = head.insn;
  assign addr_o = head.addr;

endmodule

// File: tb/tb_insn_queue.sv
// Scoreboard bench for insn_queue.
// Stimulus queues expected words; a monitor checks pops.
module tb_insn_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] insn_i = '0;
  logic [15:0] addr_i = '0;
  logic        stall_i = 1'b0;
  logic        stall_o, valid_o;
  logic [31:0] insn_o;
  logic [15:0] addr_o;
  logic [2:0]  count_o;

  typedef struct packed {
    logic [31:0] insn;
    logic [15:0] addr;
  } ent_t;

  ent_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  insn_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .valid_i(valid_i), .insn_i(insn_i), .addr_i(addr_i),
    .stall_o(stall_o), .valid_o(valid_o),
    .insn_o(insn_o), .addr_o(addr_o),
    .stall_i(stall_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer a word; acc says whether the queue should take it
  task automatic offer(input logic [31:0] w, input logic [15:0] a,
                       input bit acc);
    valid_i = 1'b1;
    insn_i  = w;
    addr_i  = a;
    if (acc) sb.push_back('{insn: w, addr: a});
  endtask

  // Monitor: a head presented with the decoder ready must match
  always @(negedge clk) begin
    if (rst && valid_o && !stall_i && !flush_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h@%h expected none",
                 insn_o, addr_o);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_insn", insn_o, e.insn);
        chk("pop_addr", {16'h0, addr_o}, {16'h0, e.addr});
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", {31'h0, valid_o}, 0);
    chk("rst_stall", {31'h0, stall_o}, 0);
    chk("rst_count", {29'h0, count_o}, 0);
    chk("rst_insn", insn_o, 0);
    chk("rst_addr", {16'h0, addr_o}, 0);
    #10 rst = 1'b1;
    step();

    // single word, one-cycle latency
    offer(32'hA000_0001, 16'h0010, 1);
    step();
    valid_i = 1'b0;
    chk("t1_count", {29'h0, count_o}, 1);
    chk("t1_valid", {31'h0, valid_o}, 1);
    chk("t1_insn", insn_o, 32'hA000_0001);
    chk("t1_addr", {16'h0, addr_o}, 32'h0010);
    step();
    chk("t1_count0", {29'h0, count_o}, 0);
    chk("t1_valid0", {31'h0, valid_o}, 0);

    // fill while stalled, fifth word refused
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(32'hC000_0000 + i, 16'h0100 + 16'(i), i < 4);
      step();
      chk("t2_count", {29'h0, count_o}, (i < 4) ? i + 1 : 4);
    end
    valid_i = 1'b0;
    chk("t2_stall", {31'h0, stall_o}, 1);
    chk("t2_hold_insn", insn_o, 32'hC000_0000);
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_drain", {29'h0, count_o}, 3 - i);
    end
    chk("t2_empty", {31'h0, valid_o}, 0);

    // full queue with continuous traffic
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'hF000_0000 + i, 16'h0200 + 16'(i), 1);
      step();
    end
    chk("t3_full", {31'h0, stall_o}, 1);
    stall_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      offer(32'hB000_0000 + 32'(k << 4), 16'h0300 + 16'(k), k != 0);
      step();
      chk("t3_stall", {31'h0, stall_o}, 0);
      chk("t3_count", {29'h0, count_o}, 3);
    end
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t3_empty", {29'h0, count_o}, 0);

    // flush with a word offered
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'hD000_0000 + i, 16'h0400 + 16'(i), 1);
      step();
    end
    chk("t4_count3", {29'h0, count_o}, 3);
    offer(32'hDEAD_BEEF, 16'h0BAD, 0);
    flush_i = 1'b1;
    stall_i = 1'b0;
    sb.delete();
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("t4_count", {29'h0, count_o}, 0);
    chk("t4_valid", {31'h0, valid_o}, 0);
    chk("t4_insn", insn_o, 0);
    step();
    chk("t4_still0", {29'h0, count_o}, 0);

    // streaming through pointer wraps
    for (int i = 0; i < 10; i++) begin
      offer(32'h5000_0000 + i, 16'h0500 + 16'(i), 1);
      step();
      chk("t5_count", {29'h0, count_o}, 1);
    end
    valid_i = 1'b0;
    step();
    chk("t5_empty", {29'h0, count_o}, 0);

    // asynchronous reset mid-operation
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      offer(32'hE000_0000 + i, 16'h0600 + 16'(i), 1);
      step();
    end
    valid_i = 1'b0;
    chk("t6_count2", {29'h0, count_o}, 2);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    chk("t6_rvalid", {31'h0, valid_o}, 0);
    chk("t6_rcount", {29'h0, count_o}, 0);
    chk("t6_rinsn", insn_o, 0);
    #2 rst = 1'b1;
    stall_i = 1'b0;
    step();
    offer(32'h1234_5678, 16'h0700, 1);
    step();
    valid_i = 1'b0;
    chk("t6_valid", {31'h0, valid_o}, 1);
    chk("t6_insn", insn_o, 32'h1234_5678);
    step();
    chk("t6_count0", {29'h0, count_o}, 0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
